// File: rtl/vd_wb_sequencer_pkg.sv
// +-----------------------------------------------------------------------------
// | vd_wb_sequencer_pkg : shared vector types and beat-count constants
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package vd_wb_sequencer_pkg;

  typedef enum logic [1:0] {
    SEW_8   = 2'd0,
    SEW_16  = 2'd1,
    SEW_32  = 2'd2,
    SEW_ILL = 2'd3
  } sew_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  // Index of the final beat for each element width (beats = 1, 2, 4).
  localparam logic [1:0] C_LAST_BEAT_8  = 2'd0;
  localparam logic [1:0] C_LAST_BEAT_16 = 2'd1;
  localparam logic [1:0] C_LAST_BEAT_32 = 2'd3;

  function automatic logic [1:0] last_beat(input sew_e sew);
    case (sew)
      SEW_8:   last_beat = C_LAST_BEAT_8;
      SEW_16:  last_beat = C_LAST_BEAT_16;
      SEW_32:  last_beat = C_LAST_BEAT_32;
      default: last_beat = C_LAST_BEAT_8;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vd_wb_sequencer_mapping_unit.sv
// +-----------------------------------------------------------------------------
// | vd_wb_sequencer_mapping_unit : arithmetic (4 x 32-bit lane) to memory word
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module vd_wb_sequencer_mapping_unit
  import vd_wb_sequencer_pkg::*;
(
  input  logic [127:0] i_data,
  input  sew_e         i_sew,
  input  logic [1:0]   i_reg_select,
  output logic [31:0]  o_word
);

  logic [31:0] w_lane [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign w_lane[g] = i_data[g*32 +: 32];
    end
  endgenerate

  // Each lane carries one element in its low bits; elements pack upward.
  always_comb begin
    o_word = '0;
    case (i_sew)
      SEW_8:   o_word = {w_lane[3][7:0], w_lane[2][7:0], w_lane[1][7:0], w_lane[0][7:0]};
      SEW_16:  o_word = i_reg_select[0] ? {w_lane[3][15:0], w_lane[2][15:0]}
                                        : {w_lane[1][15:0], w_lane[0][15:0]};
      SEW_32:  o_word = w_lane[i_reg_select];
      default: o_word = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vd_wb_sequencer.sv
// +-----------------------------------------------------------------------------
// | vd_wb_sequencer : splits a 128-bit result into register-file word writes
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module vd_wb_sequencer
  import vd_wb_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         n_reset,
  input  logic         res_valid_i,
  output logic         res_ready_o,
  input  logic [127:0] res_data_i,
  input  logic [1:0]   sew_i,
  input  logic [4:0]   vd_i,
  input  logic         flush_i,
  output logic         wr_en_o,
  input  logic         wr_ready_i,
  output logic [6:0]   wr_addr_o,
  output logic [31:0]  wr_data_o,
  output logic         done_o,
  output logic         err_o
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [1:0]   r_beat;
  logic [127:0] r_data;
  sew_e         r_sew;
  logic [4:0]   r_vd;
  logic         r_done;
  logic         r_err;

  logic         w_accept;
  logic         w_fire;
  logic         w_last;
  logic         w_illegal;

  assign w_accept  = res_valid_i & res_ready_o;
  assign w_fire    = wr_en_o & wr_ready_i;
  assign w_last    = (r_beat == last_beat(r_sew));
  assign w_illegal = (sew_i == SEW_ILL);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush wins over a word acceptance; a word taken alongside flush still counts.
  always_comb begin
    w_state_nxt = r_state;
    res_ready_o = 1'b0;
    wr_en_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        res_ready_o = 1'b1;
        if (w_accept && !w_illegal) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en_o = 1'b1;
        if (flush_i || (wr_ready_i && w_last)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_beat <= 2'd0;
      r_data <= '0;
      r_sew  <= SEW_8;
      r_vd   <= 5'd0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_fire & w_last & ~flush_i;
      r_err  <= w_accept & w_illegal;
      if (w_accept) begin
        r_data <= res_data_i;
        r_sew  <= sew_e'(sew_i);
        r_vd   <= vd_i;
        r_beat <= 2'd0;
      end else if (w_fire && !w_last) begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  vd_wb_sequencer_mapping_unit u_mapping_unit (
    .i_data       (r_data),
    .i_sew        (r_sew),
    .i_reg_select (r_beat),
    .o_word       (wr_data_o)
  );

  assign wr_addr_o = {r_vd, r_beat};
  assign done_o    = r_done;
  assign err_o     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vd_wb_sequencer.sv
// +-----------------------------------------------------------------------------
// | tb_vd_wb_sequencer : directed table plus randomized checks of vd_wb_sequencer
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_vd_wb_sequencer;

  logic         clk;
  logic         n_reset;
  logic         res_valid_i;
  logic         res_ready_o;
  logic [127:0] res_data_i;
  logic [1:0]   sew_i;
  logic [4:0]   vd_i;
  logic         flush_i;
  logic         wr_en_o;
  logic         wr_ready_i;
  logic [6:0]   wr_addr_o;
  logic [31:0]  wr_data_o;
  logic         done_o;
  logic         err_o;

  int n_vec = 0;
  int n_err = 0;

  vd_wb_sequencer dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .res_data_i  (res_data_i),
    .sew_i       (sew_i),
    .vd_i        (vd_i),
    .flush_i     (flush_i),
    .wr_en_o     (wr_en_o),
    .wr_ready_i  (wr_ready_i),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]        sew;
    logic [4:0]        vd;
    logic [127:0]      data;
    int                n_beats;
    int                stall;
    int                flush_beat;
    logic [3:0][31:0]  words;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Element e lives in the low bits of lane e; words pack consecutive elements.
  function automatic logic [31:0] model_word(input logic [127:0] d, input int sew, input int beat);
    int w;
    int epw;
    int e;
    logic [31:0] r;
    w   = 8 << sew;
    epw = 4 >> sew;
    r   = '0;
    for (int k = 0; k < epw; k++) begin
      e = beat * epw + k;
      for (int i = 0; i < w; i++) begin
        r[k*w + i] = d[e*32 + i];
      end
    end
    return r;
  endfunction

  task automatic run_seq(input logic [1:0] sew, input logic [4:0] vd, input logic [127:0] data,
                         input int n_beats, input logic [3:0][31:0] exp_words,
                         input int stall0, input int flush_beat, input int ready_pct);
    int b;
    int stall;
    int cycles;
    bit flushed;
    bit rdy;
    bit fl;
    logic [6:0] ea;
    check("ready_idle", 32'(res_ready_o), 32'd1);
    res_valid_i = 1'b1;
    sew_i       = sew;
    vd_i        = vd;
    res_data_i  = data;
    @(posedge clk);
    @(negedge clk);
    res_valid_i = 1'b0;
    res_data_i  = {$urandom, $urandom, $urandom, $urandom};
    if (sew == 2'd3) begin
      check("err_pulse", 32'(err_o), 32'd1);
      check("err_no_wr", 32'(wr_en_o), 32'd0);
      check("err_ready", 32'(res_ready_o), 32'd1);
      @(negedge clk);
      check("err_clear", 32'(err_o), 32'd0);
      check("err_no_wr2", 32'(wr_en_o), 32'd0);
      return;
    end
    check("no_err", 32'(err_o), 32'd0);
    b       = 0;
    stall   = stall0;
    cycles  = 0;
    flushed = 1'b0;
    while (b < n_beats && !flushed) begin
      ea = {vd, 2'(b)};
      check("wr_en", 32'(wr_en_o), 32'd1);
      check("wr_addr", 32'(wr_addr_o), 32'(ea));
      check("wr_data", wr_data_o, exp_words[b]);
      check("busy_ready", 32'(res_ready_o), 32'd0);
      check("early_done", 32'(done_o), 32'd0);
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else begin
        rdy = ($urandom_range(0, 99) < ready_pct);
      end
      fl          = (b == flush_beat);
      wr_ready_i  = rdy;
      flush_i     = fl;
      res_valid_i = $urandom_range(0, 1) == 1;
      sew_i       = 2'($urandom_range(0, 3));
      vd_i        = 5'($urandom_range(0, 31));
      @(posedge clk);
      @(negedge clk);
      wr_ready_i  = 1'b0;
      flush_i     = 1'b0;
      res_valid_i = 1'b0;
      if (rdy) b++;
      if (fl) flushed = 1'b1;
      cycles++;
      if (cycles > 200) begin
        check("seq_timeout", 32'd1, 32'd0);
        break;
      end
    end
    check("end_wr_en", 32'(wr_en_o), 32'd0);
    check("end_ready", 32'(res_ready_o), 32'd1);
    check("end_done", 32'(done_o), flushed ? 32'd0 : 32'd1);
    check("end_err", 32'(err_o), 32'd0);
    @(negedge clk);
    check("done_clear", 32'(done_o), 32'd0);
  endtask

  localparam logic [127:0] C_D1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] C_D2 = 128'h89ABCDEF_01234567_FEDCBA98_76543210;

  initial begin
    logic [3:0][31:0] mw;
    int s;
    int nb;
    int fb;

    tbl[0] = '{2'd2, 5'd5,  C_D1, 4, 0, -1, {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}};
    tbl[1] = '{2'd0, 5'd1,  C_D1, 1, 0, -1, {32'h0, 32'h0, 32'h0, 32'h0C080400}};
    tbl[2] = '{2'd1, 5'd9,  C_D1, 2, 3, -1, {32'h0, 32'h0, 32'h0D0C0908, 32'h05040100}};
    tbl[3] = '{2'd2, 5'd31, C_D1, 4, 0,  1, {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}};
    tbl[4] = '{2'd3, 5'd2,  C_D1, 0, 0, -1, {32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[5] = '{2'd1, 5'd3,  C_D2, 2, 1, -1, {32'h0, 32'h0, 32'hCDEF4567, 32'hBA983210}};
    tbl[6] = '{2'd0, 5'd7,  C_D2, 1, 2, -1, {32'h0, 32'h0, 32'h0, 32'hEF679810}};

    n_reset     = 1'b0;
    res_valid_i = 1'b0;
    res_data_i  = '0;
    sew_i       = 2'd0;
    vd_i        = 5'd0;
    flush_i     = 1'b0;
    wr_ready_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(res_ready_o), 32'd1);
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_addr", 32'(wr_addr_o), 32'd0);
    check("rst_data", wr_data_o, 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_seq(tbl[i].sew, tbl[i].vd, tbl[i].data, tbl[i].n_beats, tbl[i].words,
              tbl[i].stall, tbl[i].flush_beat, 100);
    end

    // Reset in the middle of a 4-beat sequence.
    res_valid_i = 1'b1;
    sew_i       = 2'd2;
    vd_i        = 5'd3;
    res_data_i  = C_D2;
    @(posedge clk);
    @(negedge clk);
    res_valid_i = 1'b0;
    wr_ready_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_wr_en", 32'(wr_en_o), 32'd1);
    check("mid_addr", 32'(wr_addr_o), 32'd13);
    check("mid_data", wr_data_o, 32'hFEDCBA98);
    n_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_reset    = 1'b1;
    wr_ready_i = 1'b0;
    check("mrst_wr_en", 32'(wr_en_o), 32'd0);
    check("mrst_ready", 32'(res_ready_o), 32'd1);
    check("mrst_addr", 32'(wr_addr_o), 32'd0);
    check("mrst_data", wr_data_o, 32'd0);
    check("mrst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    check("mrst_idle", 32'(wr_en_o), 32'd0);
    check("mrst_done2", 32'(done_o), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [127:0] d;
      logic [4:0]   v;
      d  = {$urandom, $urandom, $urandom, $urandom};
      v  = 5'($urandom_range(0, 31));
      s  = $urandom_range(0, 3);
      nb = (s == 3) ? 0 : (1 << s);
      fb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      mw = '0;
      for (int k = 0; k < nb; k++) mw[k] = model_word(d, s, k);
      run_seq(2'(s), v, d, nb, mw, $urandom_range(0, 2), fb, 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
